// File: rtl/display_mux_ctrl.sv
// Two-digit multiplexed seven-segment display controller.
// Cycles SHOW0 -> BLANK0 -> SHOW1 -> BLANK1. New digit pairs pass through a
// one-entry pending buffer and are committed to the display registers only at
// the SHOW1->BLANK1 frame boundary, so a digit never shows a torn value.
module display_mux_ctrl #(
   parameter int unsigned DIV_WIDTH = 14,
   parameter int unsigned BLANK     = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [3:0] data0,
   input  logic [3:0] data1,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       frame_done
);

   localparam int unsigned SHOW_LEN = 2 ** DIV_WIDTH;
   localparam int unsigned MAX_LEN  = (SHOW_LEN > BLANK) ? SHOW_LEN : BLANK;
   localparam int unsigned CW       = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      SHOW0,
      BLANK0,
      SHOW1,
      BLANK1
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          boundary;
   logic          show_last, blank_last;

   logic [3:0]    d0, d1;
   logic [3:0]    p0, p1;
   logic          pending_full;

   logic [1:0]    an_n;
   logic [6:0]    seg_n;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign show_last  = (cnt == CW'(SHOW_LEN - 1));
   assign blank_last = (cnt == CW'(BLANK - 1));
   assign load_ready = ~pending_full;

   // Next state, shared dwell counter and frame-boundary detect; en=0 forces
   // a held BLANK1 that is never treated as a boundary.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt + CW'(1);
      boundary = 1'b0;
      case (state)
         SHOW0:  if (show_last)  begin state_n = BLANK0; cnt_n = '0; end
         BLANK0: if (blank_last) begin state_n = SHOW1;  cnt_n = '0; end
         SHOW1:  if (show_last)  begin state_n = BLANK1; cnt_n = '0; boundary = 1'b1; end
         BLANK1: if (blank_last) begin state_n = SHOW0;  cnt_n = '0; end
         default: begin state_n = BLANK1; cnt_n = '0; end
      endcase
      if (!en) begin
         state_n  = BLANK1;
         cnt_n    = '0;
         boundary = 1'b0;
      end
   end

   // Anode/segment values for the upcoming state; registered below so the
   // pins only move on clock edges.
   always_comb begin
      an_n  = 2'b11;
      seg_n = 7'h7F;
      case (state_n)
         SHOW0: begin an_n = 2'b10; seg_n = hex7(d0); end
         SHOW1: begin an_n = 2'b01; seg_n = hex7(d1); end
         default: begin an_n = 2'b11; seg_n = 7'h7F; end
      endcase
   end

   // State and counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= BLANK1;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Registered display outputs and frame pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an         <= 2'b11;
         seg        <= 7'h7F;
         frame_done <= 1'b0;
      end else begin
         an         <= an_n;
         seg        <= seg_n;
         frame_done <= boundary;
      end
   end

   // Pending buffer: accept when empty, commit to display at a boundary.
   // Accept and commit are mutually exclusive since one needs the flag clear
   // and the other needs it set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         d0           <= '0;
         d1           <= '0;
         p0           <= '0;
         p1           <= '0;
         pending_full <= 1'b0;
      end else if (boundary && pending_full) begin
         d0           <= p0;
         d1           <= p1;
         pending_full <= 1'b0;
      end else if (load_valid && !pending_full) begin
         p0           <= data0;
         p1           <= data1;
         pending_full <= 1'b1;
      end
   end

endmodule

// File: doc/display_mux_ctrl.md
DISPLAY_MUX_CTRL -- requirements
Module: display_mux_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_WIDTH, default 14, giving a digit dwell of 2^DIV_WIDTH clock cycles.
REQ-002 The block SHALL have parameter BLANK, default 64, giving the inter-digit blanking length in clock cycles (BLANK >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock (HSOSC output).
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: display enable.
REQ-006 The block SHALL have port load_valid, input, 1 bit: new digit pair offered.
REQ-007 The block SHALL have port load_ready, output, 1 bit: pending buffer empty and able to accept a pair.
REQ-008 The block SHALL have port data0, input, 4 bits: hex value for digit 0.
REQ-009 The block SHALL have port data1, input, 4 bits: hex value for digit 1.
REQ-010 The block SHALL have port an, output, 2 bits: active-low common-anode enables, with an[0] driving digit 0.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame end.

Function
REQ-013 The FSM SHALL have states SHOW0, BLANK0, SHOW1 and BLANK1, cycling SHOW0->BLANK0->SHOW1->BLANK1->SHOW0.
REQ-014 Each SHOW state SHALL last exactly 2^DIV_WIDTH cycles, and each BLANK state SHALL last exactly BLANK cycles, both timed by one shared cycle counter that clears on every state change.
REQ-015 In SHOW0, an SHALL be 2'b10 and seg SHALL be the decode of display register d0; in SHOW1, an SHALL be 2'b01 and seg SHALL be the decode of d1.
REQ-016 In both BLANK states, an SHALL be 2'b11 and seg SHALL be 7'h7F; both anodes SHALL never be low in the same cycle.
REQ-017 The decode SHALL use these hex values: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-018 an and seg SHALL be registered outputs that change only on clk edges, so they SHALL be free of glitches.
REQ-019 load_ready SHALL equal the inverse of pending_full, where pending_full is a one-bit flag.
REQ-020 When load_valid and load_ready are both high, the block SHALL latch data0/data1 into the pending registers and set pending_full on the next edge.
REQ-021 When load_valid is high and load_ready is low, the block SHALL ignore the offered data, and the requester SHALL hold its data until it is accepted.
REQ-022 A frame boundary SHALL be the SHOW1->BLANK1 transition; on that edge, if pending_full=1, the block SHALL copy pending to d0/d1 and clear pending_full.
REQ-023 frame_done SHALL be high for exactly the one cycle after every frame boundary, whether or not a commit occurred.
REQ-024 If an accept (REQ-020) and a boundary happen on the same edge while pending is empty, the new pair SHALL go to pending and be committed at the following boundary, not the current one.
REQ-025 If an accept and a boundary happen on the same edge while pending is full, the accept cannot occur (load_ready=0); the commit SHALL occur and load_ready SHALL rise on the next cycle.
REQ-026 d0/d1 SHALL never change outside a frame boundary, so no digit SHALL ever show a torn value.
REQ-027 When en=0, the FSM SHALL enter and hold BLANK1 with the counter cleared, an=2'b11, seg=7'h7F and frame_done=0, while loads are still accepted into pending.
REQ-028 When en rises, the block SHALL complete a full BLANK1 and then enter SHOW0, and forcing BLANK1 through en=0 SHALL NOT count as a frame boundary.
REQ-029 The cycle counter SHALL be wide enough for max(2^DIV_WIDTH, BLANK) and SHALL never wrap within a state.

Reset
REQ-030 While reset_n=0, the block SHALL immediately hold state=BLANK1, counter=0, d0=d1=0, pending=0, pending_full=0, an=2'b11, seg=7'h7F, frame_done=0 and load_ready=1.
REQ-031 After reset_n rises with en=1, the block SHALL enter SHOW0 after BLANK cycles and show digit 0 as "0" (seg=7'h40).
REQ-032 When reset_n is asserted mid-frame, the block SHALL blank outputs in the same cycle without waiting for a clock edge, and SHALL lose any pending data.

Verification (DIV_WIDTH=3, BLANK=2, en=1)
REQ-033 The bench SHALL release reset and check: an=11 for 2 cycles, then an=10/seg=40 for 8 cycles, an=11 for 2 cycles, an=01/seg=40 for 8 cycles, frame period 20 cycles.
REQ-034 The bench SHALL load data0=A, data1=5 mid-SHOW0 and check: load_ready falls next cycle, digits still show 0 until the boundary, then SHOW0 seg=08 and SHOW1 seg=12, with frame_done pulsing once and load_ready=1.
REQ-035 The bench SHALL, with pending empty, offer data0=F, data1=1 on the exact boundary edge and check: the current frame still shows the old pair and the next frame shows 0E/79.
REQ-036 The bench SHALL, with pending full, hold load_valid with a second pair and check: no accept until the cycle after the boundary, that the first pair displays, and that the second pair displays one frame later.
REQ-037 The bench SHALL drive en=0 during SHOW1 and check: next cycle an=11/seg=7F and no frame_done; after en=1, an=11 for 2 cycles, then SHOW0.
REQ-038 The bench SHALL assert reset_n=0 mid-SHOW0 with pending full and check: an=11/seg=7F immediately, load_ready=1, and the display after release shows 40 on both digits.
